// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch prediction / resolution slice.
// Contents: BrOp class encodings, funct3 codes for conditional branches,
// the 2-bit saturating counter type with its four states, and the
// counter training function used by the branch history table.
package branch_predict_unit_pkg;

    // BrOp[4:3] class encodings; any value with the MSB set is a jump.
    localparam logic [1:0] BR_NONE     = 2'b00;
    localparam logic [1:0] BR_COND     = 2'b01;
    localparam logic       BR_JUMP_MSB = 1'b1;

    // funct3 codes of the conditional branches (010 and 011 are not branches).
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 2-bit saturating predictor counter; MSB is the predicted direction.
    typedef logic [1:0] ctr2_t;
    localparam ctr2_t SN = 2'b00;
    localparam ctr2_t WN = 2'b01;
    localparam ctr2_t WT = 2'b10;
    localparam ctr2_t ST = 2'b11;

    // Move a counter one step towards the resolved direction, saturating at the ends.
    function automatic ctr2_t ctr_update(input ctr2_t cur, input logic taken);
        ctr2_t nxt;
        case (cur)
            SN:      nxt = taken ? WN : SN;
            WN:      nxt = taken ? WT : SN;
            WT:      nxt = taken ? ST : WN;
            ST:      nxt = taken ? ST : WT;
            default: nxt = WN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational branch resolver, shared with the single-cycle core.
// Ports:
//   ru1, ru2  : rs1 / rs2 operands (XLEN bits)
//   br_op     : [4:3] class (00 none, 01 conditional, 1x jump), [2:0] funct3
//   taken     : resolved direction
//   is_br     : legal conditional branch
//   is_jmp    : unconditional jump
module branch_compare
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] ru1,
    input  logic [XLEN-1:0] ru2,
    input  logic [4:0]      br_op,
    output logic            taken,
    output logic            is_br,
    output logic            is_jmp
);

    // Decode the branch class and evaluate the compare selected by funct3.
    always_comb begin
        taken  = 1'b0;
        is_br  = 1'b0;
        is_jmp = 1'b0;
        if (br_op[4] == BR_JUMP_MSB) begin
            taken  = 1'b1;
            is_jmp = 1'b1;
        end else if (br_op[4:3] == BR_COND) begin
            case (br_op[2:0])
                F3_BEQ:  begin is_br = 1'b1; taken = (ru1 == ru2); end
                F3_BNE:  begin is_br = 1'b1; taken = (ru1 != ru2); end
                F3_BLT:  begin is_br = 1'b1; taken = ($signed(ru1) <  $signed(ru2)); end
                F3_BGE:  begin is_br = 1'b1; taken = ($signed(ru1) >= $signed(ru2)); end
                F3_BLTU: begin is_br = 1'b1; taken = (ru1 <  ru2); end
                F3_BGEU: begin is_br = 1'b1; taken = (ru1 >= ru2); end
                // 010 / 011 are reserved: behave as a non-branch.
                default: begin is_br = 1'b0; taken = 1'b0; end
            endcase
        end else begin
            taken = 1'b0;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict / resolve unit: BHT of 2-bit counters read by fetch,
// resolution and training in execute, mispredict flush pulse and statistics.
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   if_pc             : fetch PC; if_pred_taken is its combinational prediction
//   ex_valid, ex_pc   : execute-stage instruction valid and PC
//   ex_pred_taken     : prediction that travelled down with the instruction
//   RU1, RU2, BrOp    : operands and branch opcode of the EX instruction
//   NextPCSrc         : combinational resolved taken
//   mispredict        : registered one-cycle flush pulse
//   branch_count      : saturating count of resolved conditional branches
//   mispredict_count  : saturating count of mispredicts (branches and jumps)
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  RU1,
    input  logic [XLEN-1:0]  RU2,
    input  logic [4:0]       BrOp,
    output logic             NextPCSrc,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    ctr2_t             bht_q [BHT_ENTRIES];
    ctr2_t             bht_d [BHT_ENTRIES];
    logic              mispredict_q, mispredict_d;
    logic [CNT_W-1:0]  branch_count_q, branch_count_d;
    logic [CNT_W-1:0]  mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0]  if_idx_s;
    logic [IDX_W-1:0]  ex_idx_s;
    logic              taken_s;
    logic              is_br_s;
    logic              is_jmp_s;
    logic              unused_pc_bits_s;

    // Word-aligned PCs: bits [1:0] are dropped, the next IDX_W bits index the table.
    assign if_idx_s = if_pc[IDX_W+1:2];
    assign ex_idx_s = ex_pc[IDX_W+1:2];
    assign unused_pc_bits_s = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                                ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    branch_compare #(
        .XLEN (XLEN)
    ) u_branch_compare (
        .ru1    (RU1),
        .ru2    (RU2),
        .br_op  (BrOp),
        .taken  (taken_s),
        .is_br  (is_br_s),
        .is_jmp (is_jmp_s)
    );

    // Prediction reads registered state only; an EX update shows up next cycle.
    assign if_pred_taken    = bht_q[if_idx_s][1];
    assign NextPCSrc        = ex_valid & taken_s;
    assign mispredict       = mispredict_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    // Next-state for the BHT entry, the flush pulse and the statistics counters.
    always_comb begin
        bht_d              = bht_q;
        mispredict_d       = 1'b0;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        if (ex_valid && is_br_s) begin
            bht_d[ex_idx_s] = ctr_update(bht_q[ex_idx_s], taken_s);
            if (branch_count_q != {CNT_W{1'b1}}) begin
                branch_count_d = branch_count_q + CNT_W'(1);
            end else begin
                branch_count_d = branch_count_q;
            end
        end else begin
            bht_d = bht_q;
        end

        if (ex_valid && (is_br_s || is_jmp_s) && (NextPCSrc != ex_pred_taken)) begin
            mispredict_d = 1'b1;
            if (mispredict_count_q != {CNT_W{1'b1}}) begin
                mispredict_count_d = mispredict_count_q + CNT_W'(1);
            end else begin
                mispredict_count_d = mispredict_count_q;
            end
        end else begin
            mispredict_d = 1'b0;
        end
    end

    // State registers; reset puts every predictor entry at weakly-not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= WN;
            end
            mispredict_q       <= 1'b0;
            branch_count_q     <= {CNT_W{1'b0}};
            mispredict_count_q <= {CNT_W{1'b0}};
        end else begin
            bht_q              <= bht_d;
            mispredict_q       <= mispredict_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule
